// File: rtl/lcd_cmd_sequencer.sv
// LCD command/message sequencer: issues the init command list followed by the ROM text, one transfer at a time.
// Define LCD_LINE2_EN to append the DDRAM 0x40 address and the second text line.
module lcd_cmd_sequencer #(
   parameter int CLEAR_DELAY = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       init_done,
   input  logic       start,
   input  logic       done,
   input  logic       enable,
   output logic       next_instruction,
   output logic [9:0] db,
   output logic [11:0] clk_cnt,
   output logic       busy,
   output logic       seq_done
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      GAP,
      CLEAR_WAIT,
      FINISHED
   } state_t;

`ifdef LCD_LINE2_EN
   localparam int N_XFER = 38;
   localparam logic [127:0] LINE2 = "FPGA LCD DEMO   ";
`else
   localparam int N_XFER = 21;
`endif
   localparam logic [127:0] LINE1     = "HELLO WORLD     ";
   localparam logic [5:0]   LAST      = 6'(N_XFER - 1);
   localparam logic [9:0]   CMD_CLEAR = 10'h001;
   localparam logic [16:0]  DLY_LOAD  = 17'(CLEAR_DELAY - 1);

   state_t      state;
   logic [5:0]  idx;
   logic [16:0] dly_cnt;

   // Character k of a 16-char line sits at bits [8*(15-k) +: 8]; 15-k is ~k for a 4-bit k.
   function automatic logic [9:0] rom_word(input logic [5:0] i);
      logic [9:0] w;
      logic [3:0] k;
      logic [6:0] sh;
      w  = 10'h000;
      k  = 4'd0;
      sh = 7'd0;
      if (i < 6'd5) begin
         case (i)
            6'd0:    w = 10'h028;
            6'd1:    w = 10'h006;
            6'd2:    w = 10'h00C;
            6'd3:    w = 10'h001;
            default: w = 10'h080;
         endcase
      end else if (i < 6'd21) begin
         k  = 4'(i - 6'd5);
         sh = {~k, 3'b000};
         w  = {2'b10, LINE1[sh +: 8]};
`ifdef LCD_LINE2_EN
      end else if (i == 6'd21) begin
         w = 10'h0C0;
      end else if (i < 6'd38) begin
         k  = 4'(i - 6'd22);
         sh = {~k, 3'b000};
         w  = {2'b10, LINE2[sh +: 8]};
`endif
      end
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= IDLE;
         idx              <= 6'd0;
         dly_cnt          <= 17'd0;
         next_instruction <= 1'b0;
         db               <= 10'h000;
         clk_cnt          <= 12'd0;
         busy             <= 1'b0;
         seq_done         <= 1'b0;
      end else begin
         if (!enable)
            clk_cnt <= 12'd0;
         else if (clk_cnt != 12'hFFF)
            clk_cnt <= clk_cnt + 12'd1;

         next_instruction <= 1'b0;
         case (state)
            IDLE, FINISHED: begin
               if (start && init_done) begin
                  state            <= ISSUE;
                  idx              <= 6'd0;
                  db               <= rom_word(6'd0);
                  next_instruction <= ~enable;
                  busy             <= 1'b1;
                  seq_done         <= 1'b0;
               end
            end
            // Launch is held off while the downstream FSM is still mid-transfer.
            ISSUE: begin
               if (next_instruction)
                  state <= WAIT_DONE;
               else
                  next_instruction <= ~enable;
            end
            WAIT_DONE: begin
               if (done) begin
                  idx <= idx + 6'd1;
                  if (idx == LAST) begin
                     state    <= FINISHED;
                     busy     <= 1'b0;
                     seq_done <= 1'b1;
                  end else if (db == CMD_CLEAR) begin
                     state   <= CLEAR_WAIT;
                     dly_cnt <= DLY_LOAD;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               state            <= ISSUE;
               db               <= rom_word(idx);
               next_instruction <= ~enable;
            end
            CLEAR_WAIT: begin
               if (dly_cnt == 17'd0) begin
                  state            <= ISSUE;
                  db               <= rom_word(idx);
                  next_instruction <= ~enable;
               end else begin
                  dly_cnt <= dly_cnt - 17'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 Parameter CLEAR_DELAY, default 82000: idle cycles inserted after the Clear Display transfer completes (1.64 ms at 50 MHz).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 init_done  in  1  power-on LCD initialisation complete; level.
REQ-005 start  in  1  request to run the command/message sequence; sampled only in IDLE.
REQ-006 done  in  1  one-cycle pulse from the downstream instruction FSM: current transfer finished.
REQ-007 enable  in  1  high while the downstream instruction FSM is mid-transfer.
REQ-008 next_instruction  out  1  one-cycle pulse launching one transfer downstream.
REQ-009 db  out  10  transfer word: [9]=RS, [8]=RW, [7:0]=data byte.
REQ-010 clk_cnt  out  12  transfer timing count consumed by the instruction FSM.
REQ-011 busy  out  1  high from the cycle after start is accepted until seq_done rises.
REQ-012 seq_done  out  1  sequence complete; level.

Function
REQ-013 States SHALL be IDLE, ISSUE, WAIT_DONE, GAP, CLEAR_WAIT and FINISHED; all outputs are registered.
REQ-014 Transfer list SHALL be, in order:
- 0x028 (Function Set)
- 0x006 (Entry Mode)
- 0x00C (Display On)
- 0x001 (Clear)
- 0x080 (DDRAM addr 0)
- 16 characters {2'b10, ASCII} from ROM line 1 "HELLO WORLD     "
REQ-015 IDLE->ISSUE when start=1 and init_done=1; start with init_done=0 is ignored and not remembered.
REQ-016 In ISSUE, next_instruction=1 for exactly one cycle and db presents the current list entry; the next state is WAIT_DONE.
REQ-017 db SHALL stay stable from its next_instruction cycle until the cycle after done is sampled.
REQ-018 In WAIT_DONE, done=1 advances the list index; the next state is CLEAR_WAIT if the entry was 0x001, FINISHED if it was the last entry, else GAP.
REQ-019 GAP lasts one cycle, then ISSUE: if done is sampled at edge N, the next next_instruction is high in cycle N+2.
REQ-020 CLEAR_WAIT SHALL last exactly CLEAR_DELAY cycles using a 17-bit down-counter, then go to ISSUE.
REQ-021 next_instruction SHALL never assert while enable=1 or while in WAIT_DONE, GAP or CLEAR_WAIT.
REQ-022 done sampled outside WAIT_DONE SHALL be ignored.
REQ-023 clk_cnt SHALL be 0 while enable=0, increment by 1 each cycle while enable=1, and saturate at 4095 (no wrap).
REQ-024 FINISHED: seq_done=1, busy=0; start=1 with init_done=1 clears seq_done, resets the index to 0 and enters ISSUE.
REQ-025 start while busy SHALL be ignored.

Reset
REQ-026 When reset=0 at a clock edge, the block SHALL enter IDLE, clear the index and the delay counter, and drive next_instruction=0, db=0, clk_cnt=0, busy=0, seq_done=0.
REQ-027 Reset mid-sequence SHALL abandon the sequence; after reset releases, no next_instruction is issued until a new start.

Configuration
REQ-028 Macro LCD_LINE2_EN:
- Defined: after line 1, append 0x0C0 (DDRAM 0x40) and 16 characters of ROM line 2 "FPGA LCD DEMO   ", for 38 transfers total.
- Undefined: the sequence ends after line 1 (21 transfers) and the line-2 ROM is not built.

Verification
REQ-029 Reset, then init_done=1 and start pulse -> next_instruction in the following cycle with db=0x028; busy=1.
REQ-030 Model FSM returns done 2081 cycles after each launch -> db sequence 0x028, 0x006, 0x00C, 0x001, 0x080, 0x248 ('H')...0x220; seq_done=1 after transfer 21 (38 with LCD_LINE2_EN, where transfer 22 is 0x0C0).
REQ-031 CLEAR_DELAY=10, done for 0x001 sampled at edge N -> next next_instruction in cycle N+11 with db=0x080; normal entries follow at N+2.
REQ-032 enable held high 5000 cycles -> clk_cnt reaches 4095 and holds; enable low -> clk_cnt=0 next cycle.
REQ-033 Spurious done in GAP/IDLE, and start while busy -> no index change and no extra next_instruction.
REQ-034 reset=0 during character 7 -> all outputs reset next edge; no next_instruction until a new start, which restarts at 0x028.
